// File: rtl/trace_monitor.sv
// Value-change trace sink: timestamps changes of x/y/z into a FIFO drained over valid/ready. Optional TRACE_MONITOR_TS_EN adds the timestamp counter.
// Latency: an entry sampled at edge N is visible on rd_* after edge N (first-word fall-through).
// Backpressure: rd_ready stalls the FIFO; pushes into a full FIFO without a same-cycle pop are dropped and set sticky overflow.
module trace_monitor #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       sample_en,
    input  logic [WIDTH-1:0]           x_in,
    input  logic [WIDTH-1:0]           y_in,
    input  logic [WIDTH-1:0]           z_in,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [TS_WIDTH-1:0]        rd_ts,
    output logic [WIDTH-1:0]           rd_x,
    output logic [WIDTH-1:0]           rd_y,
    output logic [WIDTH-1:0]           rd_z,
    output logic [2:0]                 rd_mask,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] z;
        logic [2:0]       mask;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             ovf;
    logic             primed;
    logic [WIDTH-1:0] sx;
    logic [WIDTH-1:0] sy;
    logic [WIDTH-1:0] sz;

    logic [2:0] ev_mask;
    logic       push_req;
    logic       do_pop;
    logic       do_push;
    logic       drop;
    logic       full;
    entry_t     head;

    assign full     = (cnt == FULL_CNT);
    assign rd_valid = (cnt != '0);
    assign ev_mask  = primed ? {z_in != sz, y_in != sy, x_in != sx} : 3'b111;
    assign push_req = sample_en && !clear && (ev_mask != 3'b000);
    assign do_pop   = rd_valid && rd_ready && !clear;
    // A same-cycle pop frees the head slot, so a full FIFO still accepts the push.
    assign do_push  = push_req && (!full || do_pop);
    assign drop     = push_req && full && !do_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            primed <= 1'b0;
            sx     <= '0;
            sy     <= '0;
            sz     <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            primed <= 1'b0;
        end else begin
            if (sample_en) begin
                sx     <= x_in;
                sy     <= y_in;
                sz     <= z_in;
                primed <= 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= '{x: x_in, y: y_in, z: z_in, mask: ev_mask};
        end
    end

    assign head     = mem[rd_ptr];
    assign rd_x     = rd_valid ? head.x    : '0;
    assign rd_y     = rd_valid ? head.y    : '0;
    assign rd_z     = rd_valid ? head.z    : '0;
    assign rd_mask  = rd_valid ? head.mask : '0;
    assign count    = cnt;
    assign overflow = ovf;

`ifdef TRACE_MONITOR_TS_EN
    localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] ts_mem [DEPTH];

    // Free-running; clear does not disturb the time base.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            ts_mem[wr_ptr] <= ts;
        end
    end

    assign rd_ts = rd_valid ? ts_mem[rd_ptr] : '0;
`else
    assign rd_ts = '0;
`endif

endmodule

// File: doc/trace_monitor.md
# trace_monitor

Synthesizable hardware counterpart of the lab's `$monitor` testbench idiom. It samples three WIDTH-bit observed values (x, y, z) every enabled cycle and detects which of them changed. Each change event is recorded as a timestamped entry in an internal FIFO, and a consumer drains the FIFO through a valid/ready read port. It sits beside the CPU datapath as a debug/trace sink, the reader end of value-change reporting.

## Interface
Parameters:
- WIDTH, 32, width of each observed value
- DEPTH, 8, FIFO entries; power of two, ≥2
- TS_WIDTH, 16, timestamp counter width

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- clear  input  1  synchronous flush (see Operation)
- sample_en  input  1  sample x_in/y_in/z_in this cycle
- x_in  input  WIDTH  observed value x
- y_in  input  WIDTH  observed value y
- z_in  input  WIDTH  observed value z
- rd_valid  output  1  head entry available
- rd_ready  input  1  consumer accepts head entry
- rd_ts  output  TS_WIDTH  head entry timestamp
- rd_x / rd_y / rd_z  output  WIDTH  head entry values
- rd_mask  output  3  head entry change mask {z,y,x}
- count  output  $clog2(DEPTH)+1  entries held
- overflow  output  1  sticky: an event was dropped

## Operation
- Timestamp counter ts: increments by 1 every cycle, wraps modulo 2^TS_WIDTH from all-ones to 0.
- Shadow registers sx/sy/sz hold the last sampled values. A `primed` flag is cleared on reset and on clear.
- On a cycle with sample_en=1:
  - If primed=0, the event mask is 3'b111.
  - Otherwise the mask is {z_in≠sz, y_in≠sy, x_in≠sx}.
  - If the mask is nonzero, push {ts, x_in, y_in, z_in, mask}.
  - Shadows always load the inputs, and primed is set to 1.
- With sample_en=0 there is no sampling, no push, and the shadows hold.
- Push when full with no pop in the same cycle: the entry is dropped, overflow is set to 1, and the shadows still update.
- Pop occurs when rd_valid && rd_ready. rd_* present the head entry (first-word fall-through).
- Push and pop in the same cycle: both occur and count is unchanged. This applies even when the FIFO is full; the push is accepted.
- Pop when empty: ignored.
- clear=1 empties the FIFO (count=0), clears overflow and primed, and ignores any sample that cycle. ts is not affected.
- clear takes priority over push and pop.
- Pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.

## Timing
- Reset values (rst_n=0 at an edge):
  - rd_valid=0, count=0, overflow=0.
  - rd_ts/rd_x/rd_y/rd_z/rd_mask=0.
  - ts=0, primed=0, shadows=0.
- Reset overrides clear and any in-flight handshake. Reset mid-operation discards all entries.
- Capture latency: a sample taken at edge N is recorded with rd_ts = ts value before edge N. rd_valid rises after edge N when the FIFO was previously empty.
- Pop at edge N: the next entry (or rd_valid=0) appears after edge N.
- count and overflow are registered and update at the same edge as the push or pop.
- rd_* outputs are 0 whenever rd_valid=0.

## Configuration
- TRACE_MONITOR_TS_EN defined:
  - ts counter instantiated.
  - Each entry stores the timestamp, and rd_ts carries it.
- Not defined:
  - No ts counter or timestamp storage.
  - rd_ts is tied to 0. The port remains, so the interface is unchanged.
  - All other behaviour identical.

## Test plan
- Reset, then sample_en=1 with x=5, y=0, z=0 at ts=10 → one entry {ts=10, x=5, y=0, z=0, mask=111}, count=1.
- Hold inputs constant for 5 sampled cycles → no new entries, count stays 1.
- Set y=6 at ts=20, then z=7 at ts=30, rd_ready=0 → entries with mask=010 (ts 20) then mask=100 (ts 30). Raise rd_ready → popped in order 10, 20, 30, then rd_valid=0.
- DEPTH=8, rd_ready=0, x changing every cycle for 10 samples → count=8, overflow=1, first 8 entries retained. The next pop+push in the same cycle keeps count=8.
- Assert clear with count=3 → count=0, overflow=0. The next sample records mask=111 regardless of values.
- TS_WIDTH=4, sample at ts=15, then after 1 cycle with x changed → second entry rd_ts=0 (wrap). Build without TRACE_MONITOR_TS_EN → rd_ts=0 for all entries, all other fields identical.
